pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed 16-bit inter-stage pipeline registers of the MISC-V datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data payload between stages with a valid/ready handshake, flush/bubble insertion and an optional skid entry.
- With the skid entry, a stall from the downstream stage no longer propagates combinationally upstream.
- One instance is placed per stage boundary.

Parameters:
- CTRL_W, 4, width of the control bundle (e.g. RegWrite, MemWrite, MemRead, RegStore).
- DATA_W, 64, width of the data payload (e.g. PC+2, ALU result, 3rd arg, Rd, each 16 bits).
- SKID, 1:
  - 1 = two-entry stage (main + skid), in_ready is registered.
  - 0 = single-entry stage, in_ready is combinational.

Ports:
- CLK  input  1  clock, rising edge
- Reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream holds a valid item
- in_ready  output  1  stage accepts an item this cycle
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream payload
- flush  input  1  discard all held items (branch/exception kill)
- out_valid  output  1  main entry holds a valid item
- out_ready  input  1  downstream consumes the item this cycle
- out_ctrl  output  CTRL_W  control of the main entry; forced to 0 when out_valid=0
- out_data  output  DATA_W  payload of the main entry; 0 after reset or flush
- occupancy  output  2  number of held items, 0..2

Behaviour:
- Events:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
  - All state changes happen on the rising edge of CLK.
- Reset (synchronous, active-high):
  - Clears both entries: out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=1 in the cycle after reset.
  - Reset has priority over flush and over all handshake events.
- Flush:
  - Same effect as reset on all state and outputs.
  - Any item presented on the input in the same cycle is dropped, even if in_ready=1.
  - Priority: Reset > flush > handshake.
- Bubble rule: out_ctrl is 0 whenever out_valid=0, so a downstream stage that ignores valid still sees a no-op. This is enforced in the register, not by masking at the output.
- Latency: an item accepted in cycle N appears on out_* in cycle N+1, provided the main entry is free or is consumed in cycle N.
- SKID=1 state machine (state = occupancy):
  - EMPTY (0):
    - in_ready=1.
    - Accept -> main loads input -> ONE.
  - ONE (1):
    - in_ready=1.
    - Accept & Consume: main loads input, stays ONE.
    - Accept & !Consume: skid loads input -> TWO.
    - !Accept & Consume -> EMPTY.
    - Otherwise: hold.
  - TWO (2):
    - in_ready=0.
    - Consume: main loads skid, skid cleared -> ONE.
    - Otherwise: hold.
  - in_ready is a flop equal to (next occupancy != 2); it has no combinational dependence on out_ready.
- SKID=0:
  - Single entry, occupancy is 0 or 1.
  - in_ready = !out_valid | out_ready (combinational).
  - Accept loads main; Consume without Accept clears valid and ctrl.
- Ordering: items leave strictly in acceptance order; none is dropped or duplicated except by flush or reset.
- Holding: while not consumed, out_ctrl and out_data are stable. Upstream must hold in_* stable while in_valid=1 and in_ready=0.
- Skid entry: not visible on any port except through occupancy.

Decomposition:
- Shared package pipe_pkg:
  - MISC-V stage-bundle widths: CTRL_W_EXMEM=4, DATA_W_EXMEM=64, and the widths for the other stages.
  - Field offset constants, used to slice PC+2, ALUResult, 3rdArg and Rd out of the payload.
  - Occupancy encodings OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
- Sub-module pipe_entry: one storage entry (valid, ctrl, data) with load, clear and bubble-zeroing. It is instantiated once as main and, when SKID=1, once as skid.

Test Plan:
- Reset mid-stream: occupancy=2 holding ctrl=0xF, data=0x1234, then Reset=1 for one cycle -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
- Streaming, out_ready held 1: present items 1,2,3 on consecutive cycles (ctrl=0x1/0x2/0x3, data=0x0001/0x0002/0x0003) -> each appears one cycle later, occupancy stays 1, in_ready stays 1.
- Stall fill (SKID=1): out_ready=0, present items A (ctrl 0x5) and B (ctrl 0x6) -> occupancy goes 1 then 2, in_ready=0 in the cycle after B is accepted. Raise out_ready -> A then B appear on successive cycles with no loss.
- Flush with simultaneous input: occupancy=2, flush=1 while in_valid=1 with ctrl=0x9 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; item 0x9 never appears.
- Bubble masking: drain the stage to empty -> out_ctrl=0 in every cycle with out_valid=0, including the cycle immediately after the last consume.
- SKID=0 instance: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> replacement item appears next cycle, occupancy stays 1.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared MISC-V stage-bundle widths, payload field offsets and occupancy encodings
// for the inter-stage pipeline registers.
package pipe_pkg;

    localparam int CTRL_W_IFID  = 1;
    localparam int DATA_W_IFID  = 32;
    localparam int CTRL_W_IDEX  = 4;
    localparam int DATA_W_IDEX  = 64;
    localparam int CTRL_W_EXMEM = 4;
    localparam int DATA_W_EXMEM = 64;
    localparam int CTRL_W_MEMWB = 2;
    localparam int DATA_W_MEMWB = 48;

    // Payload is four 16-bit fields packed MSB-first: PC+2, ALUResult, 3rdArg, Rd.
    localparam int FIELD_W    = 16;
    localparam int OFS_PC2    = 48;
    localparam int OFS_ALU    = 32;
    localparam int OFS_ARG3   = 16;
    localparam int OFS_RD     = 0;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    function automatic logic [FIELD_W-1:0] get_field(input logic [63:0] payload,
                                                     input int unsigned ofs);
        return payload[ofs +: FIELD_W];
    endfunction

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One pipeline storage entry: valid, control bundle and payload, with load,
// clear (drop valid and ctrl) and kill (zero everything).
module pipe_entry #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              kill,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // ctrl is zeroed together with valid so an empty entry always reads as a no-op.
    always_ff @(posedge CLK) begin
        if (kill) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= load_ctrl;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an
// optional skid entry that keeps in_ready off the downstream combinational path.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 64,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              kill;
    logic              accept;
    logic              consume;
    logic              main_load;
    logic              main_from_skid;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic [1:0]        occ_nxt;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;

    assign kill    = Reset | flush;
    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // The skid entry is only ever filled while main is full, so its valid marks TWO.
    assign occupancy = skid_valid ? OCC_TWO : (out_valid ? OCC_ONE : OCC_EMPTY);

    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        occ_nxt        = occupancy;
        if (SKID != 0) begin
            case (occupancy)
                OCC_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        occ_nxt   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        occ_nxt   = OCC_TWO;
                    end else if (consume) begin
                        main_clear = 1'b1;
                        occ_nxt    = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (consume) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        occ_nxt        = OCC_ONE;
                    end
                end
                default: ;
            endcase
        end else begin
            if (accept) begin
                main_load = 1'b1;
                occ_nxt   = OCC_ONE;
            end else if (consume) begin
                main_clear = 1'b1;
                occ_nxt    = OCC_EMPTY;
            end
        end
    end

    assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_in = main_from_skid ? skid_data : in_data;

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .CLK       (CLK),
        .kill      (kill),
        .load      (main_load),
        .clear     (main_clear),
        .load_ctrl (main_ctrl_in),
        .load_data (main_data_in),
        .valid     (out_valid),
        .ctrl      (out_ctrl),
        .data      (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .CLK       (CLK),
                .kill      (kill),
                .load      (skid_load),
                .clear     (skid_clear),
                .load_ctrl (in_ctrl),
                .load_data (in_data),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .data      (skid_data)
            );

            always_ff @(posedge CLK) begin
                if (kill) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (occ_nxt != OCC_TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            logic unused_noskid;

            assign skid_valid    = 1'b0;
            assign skid_ctrl     = '0;
            assign skid_data     = '0;
            assign in_ready      = ~out_valid | out_ready;
            assign unused_noskid = ^{skid_load, skid_clear, occ_nxt};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed, table-driven bench for pipe_stage_skid (SKID=1) plus hand-written
// sequences for a SKID=0 instance.
module tb_pipe_stage_skid;

    logic        CLK;
    logic        Reset;

    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [3:0]  in_ctrl, out_ctrl;
    logic [63:0] in_data, out_data;
    logic [1:0]  occupancy;

    logic        in_valid0, in_ready0, flush0, out_valid0, out_ready0;
    logic [3:0]  in_ctrl0, out_ctrl0;
    logic [63:0] in_data0, out_data0;
    logic [1:0]  occupancy0;

    int checks   = 0;
    int failures = 0;

    pipe_stage_skid #(.CTRL_W(4), .DATA_W(64), .SKID(1)) dut1 (
        .CLK(CLK), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.CTRL_W(4), .DATA_W(64), .SKID(0)) dut0 (
        .CLK(CLK), .Reset(Reset),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .flush(flush0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .occupancy(occupancy0)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        rst, fl, iv;
        logic [3:0]  ictrl;
        logic [63:0] idata;
        logic        ordy;
        logic        ov;
        logic [3:0]  octrl;
        logic [63:0] odata;
        logic [1:0]  occ;
        logic        irdy;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [3:0] ictrl, input logic [63:0] idata,
                                input logic ordy, input logic ov, input logic [3:0] octrl,
                                input logic [63:0] odata, input logic [1:0] occ,
                                input logic irdy);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ictrl = ictrl; v.idata = idata;
        v.ordy = ordy; v.ov = ov; v.octrl = octrl; v.odata = odata; v.occ = occ;
        v.irdy = irdy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Expected values are the outputs observed just after the edge that
        // consumes the listed inputs.
        //            rst fl iv ctrl  data      ordy  ov ctrl  data      occ irdy
        vecs[0]  = mk(1, 0, 0, 4'h0, 64'h0,     0,    0, 4'h0, 64'h0,    0,  1);
        vecs[1]  = mk(0, 0, 1, 4'h1, 64'h1,     1,    1, 4'h1, 64'h1,    1,  1);
        vecs[2]  = mk(0, 0, 1, 4'h2, 64'h2,     1,    1, 4'h2, 64'h2,    1,  1);
        vecs[3]  = mk(0, 0, 1, 4'h3, 64'h3,     1,    1, 4'h3, 64'h3,    1,  1);
        vecs[4]  = mk(0, 0, 0, 4'h0, 64'h0,     1,    0, 4'h0, 64'h3,    0,  1);
        vecs[5]  = mk(0, 0, 1, 4'h5, 64'hA,     0,    1, 4'h5, 64'hA,    1,  1);
        vecs[6]  = mk(0, 0, 1, 4'h6, 64'hB,     0,    1, 4'h5, 64'hA,    2,  0);
        vecs[7]  = mk(0, 0, 1, 4'h7, 64'hC,     0,    1, 4'h5, 64'hA,    2,  0);
        vecs[8]  = mk(0, 0, 0, 4'h0, 64'h0,     1,    1, 4'h6, 64'hB,    1,  1);
        vecs[9]  = mk(0, 0, 0, 4'h0, 64'h0,     1,    0, 4'h0, 64'hB,    0,  1);
        vecs[10] = mk(0, 0, 1, 4'hF, 64'h1234,  0,    1, 4'hF, 64'h1234, 1,  1);
        vecs[11] = mk(0, 0, 1, 4'hE, 64'h5678,  0,    1, 4'hF, 64'h1234, 2,  0);
        vecs[12] = mk(0, 1, 1, 4'h9, 64'h99,    0,    0, 4'h0, 64'h0,    0,  1);
        vecs[13] = mk(0, 0, 0, 4'h0, 64'h0,     0,    0, 4'h0, 64'h0,    0,  1);
        vecs[14] = mk(0, 0, 1, 4'h9, 64'h99,    0,    1, 4'h9, 64'h99,   1,  1);
        vecs[15] = mk(0, 1, 1, 4'hA, 64'hAA,    0,    0, 4'h0, 64'h0,    0,  1);
        vecs[16] = mk(0, 0, 0, 4'h0, 64'h0,     0,    0, 4'h0, 64'h0,    0,  1);
        vecs[17] = mk(0, 0, 1, 4'hF, 64'h1234,  0,    1, 4'hF, 64'h1234, 1,  1);
        vecs[18] = mk(0, 0, 1, 4'hE, 64'h5678,  0,    1, 4'hF, 64'h1234, 2,  0);
        vecs[19] = mk(1, 1, 1, 4'hE, 64'h5678,  1,    0, 4'h0, 64'h0,    0,  1);
        vecs[20] = mk(0, 0, 0, 4'h0, 64'h0,     0,    0, 4'h0, 64'h0,    0,  1);
        vecs[21] = mk(0, 0, 1, 4'h3, 64'h33,    1,    1, 4'h3, 64'h33,   1,  1);
        vecs[22] = mk(0, 0, 1, 4'h4, 64'h44,    0,    1, 4'h3, 64'h33,   2,  0);
        vecs[23] = mk(0, 0, 0, 4'h0, 64'h0,     1,    1, 4'h4, 64'h44,   1,  1);
        vecs[24] = mk(0, 0, 1, 4'h5, 64'h55,    1,    1, 4'h5, 64'h55,   1,  1);
        vecs[25] = mk(0, 0, 0, 4'h0, 64'h0,     1,    0, 4'h0, 64'h55,   0,  1);

        in_valid0 = 1'b0; in_ctrl0 = '0; in_data0 = '0; flush0 = 1'b0; out_ready0 = 1'b0;

        for (int i = 0; i < NV; i++) begin
            Reset     = vecs[i].rst;
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_ctrl   = vecs[i].ictrl;
            in_data   = vecs[i].idata;
            out_ready = vecs[i].ordy;
            tick();
            check($sformatf("v%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
            check($sformatf("v%0d.out_ctrl",  i), 64'(out_ctrl),  64'(vecs[i].octrl));
            check($sformatf("v%0d.out_data",  i), out_data,       vecs[i].odata);
            check($sformatf("v%0d.occupancy", i), 64'(occupancy), 64'(vecs[i].occ));
            check($sformatf("v%0d.in_ready",  i), 64'(in_ready),  64'(vecs[i].irdy));
        end

        Reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // SKID=0 instance: dut0 was reset by vector 0 and has been idle since.
        check("s0.reset_valid", 64'(out_valid0), 64'(0));
        check("s0.reset_occ",   64'(occupancy0), 64'(0));
        in_valid0 = 1'b1; in_ctrl0 = 4'h2; in_data0 = 64'h22; out_ready0 = 1'b0;
        tick();
        in_valid0 = 1'b0;
        check("s0.load_valid", 64'(out_valid0), 64'(1));
        check("s0.load_ctrl",  64'(out_ctrl0),  64'(4'h2));
        check("s0.load_data",  out_data0,       64'h22);
        check("s0.stall_in_ready", 64'(in_ready0), 64'(0));
        out_ready0 = 1'b1;
        #1;
        check("s0.comb_in_ready", 64'(in_ready0), 64'(1));
        in_valid0 = 1'b1; in_ctrl0 = 4'h3; in_data0 = 64'h33;
        tick();
        check("s0.replace_valid", 64'(out_valid0), 64'(1));
        check("s0.replace_ctrl",  64'(out_ctrl0),  64'(4'h3));
        check("s0.replace_data",  out_data0,       64'h33);
        check("s0.replace_occ",   64'(occupancy0), 64'(1));
        in_valid0 = 1'b0;
        tick();
        check("s0.drain_valid", 64'(out_valid0), 64'(0));
        check("s0.drain_ctrl",  64'(out_ctrl0),  64'(0));
        check("s0.drain_occ",   64'(occupancy0), 64'(0));
        in_valid0 = 1'b1; in_ctrl0 = 4'h7; in_data0 = 64'h77; out_ready0 = 1'b0;
        tick();
        flush0 = 1'b1; in_ctrl0 = 4'h8; in_data0 = 64'h88;
        tick();
        flush0 = 1'b0; in_valid0 = 1'b0;
        check("s0.flush_valid", 64'(out_valid0), 64'(0));
        check("s0.flush_ctrl",  64'(out_ctrl0),  64'(0));
        check("s0.flush_data",  out_data0,       64'h0);
        check("s0.flush_ready", 64'(in_ready0),  64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
